// File: rtl/axi_io_responder.sv
// AXI burst responder backed by a small word memory.
// Write and read channels run independent FSMs, each with at most one burst in flight.
// Start addresses outside the window get DECERR; unsupported bursts get SLVERR.
module axi_io_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h6000_0000,
    parameter int          DEPTH_LOG2 = 8
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_axi_io_awaddr,
    input  logic [7:0]  s_axi_io_awlen,
    input  logic [1:0]  s_axi_io_awburst,
    input  logic        s_axi_io_awvalid,
    output logic        s_axi_io_awready,
    input  logic [31:0] s_axi_io_wdata,
    input  logic [3:0]  s_axi_io_wstrb,
    input  logic        s_axi_io_wlast,
    input  logic        s_axi_io_wvalid,
    output logic        s_axi_io_wready,
    output logic [1:0]  s_axi_io_bresp,
    output logic        s_axi_io_bvalid,
    input  logic        s_axi_io_bready,
    input  logic [31:0] s_axi_io_araddr,
    input  logic [7:0]  s_axi_io_arlen,
    input  logic [1:0]  s_axi_io_arburst,
    input  logic        s_axi_io_arvalid,
    output logic        s_axi_io_arready,
    output logic [31:0] s_axi_io_rdata,
    output logic [1:0]  s_axi_io_rresp,
    output logic        s_axi_io_rlast,
    output logic        s_axi_io_rvalid,
    input  logic        s_axi_io_rready
);

    localparam int          WORDS       = 1 << DEPTH_LOG2;
    localparam logic [32:0] WIN_LO      = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI      = WIN_LO + (33'd4 << DEPTH_LOG2);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [1:0]  BURST_INCR  = 2'b01;

    // Error class of a burst, decided once from its start address and burst type.
    // The window bound is compared in 33 bits so a window ending at 4 GiB does not wrap.
    function automatic logic [1:0] classify(input logic [31:0] addr, input logic [1:0] burst);
        logic [32:0] a;
        a = {1'b0, addr};
        if (a < WIN_LO || a >= WIN_HI) begin
            return RESP_DECERR;
        end else if (burst[1]) begin
            return RESP_SLVERR;
        end else begin
            return RESP_OKAY;
        end
    endfunction

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    logic [31:0] mem [WORDS];

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;

    logic [DEPTH_LOG2-1:0] widx, ridx;
    logic [7:0]            wlen, wcnt, rlen, rcnt;
    logic [1:0]            wburst, rburst, wcls, rcls;
    logic                  wlast_bad;
    logic                  aw_hs, w_hs, ar_hs, r_hs, w_final, r_final;

    assign aw_hs   = s_axi_io_awvalid && s_axi_io_awready;
    assign w_hs    = s_axi_io_wvalid && s_axi_io_wready;
    assign ar_hs   = s_axi_io_arvalid && s_axi_io_arready;
    assign r_hs    = s_axi_io_rvalid && s_axi_io_rready;
    assign w_final = (wcnt == wlen);
    assign r_final = (rcnt == rlen);

    // Write FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wstate <= W_IDLE;
        end else begin
            wstate <= wstate_nxt;
        end
    end

    // Write FSM next state and AW/W/B channel outputs; ready is held low during reset.
    always_comb begin
        wstate_nxt       = wstate;
        s_axi_io_awready = 1'b0;
        s_axi_io_wready  = 1'b0;
        s_axi_io_bvalid  = 1'b0;
        s_axi_io_bresp   = RESP_OKAY;
        case (wstate)
            W_IDLE: begin
                s_axi_io_awready = !areset;
                if (s_axi_io_awvalid && !areset) begin
                    wstate_nxt = W_DATA;
                end
            end
            W_DATA: begin
                s_axi_io_wready = 1'b1;
                if (s_axi_io_wvalid && w_final) begin
                    wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_io_bvalid = 1'b1;
                if (wcls == RESP_DECERR) begin
                    s_axi_io_bresp = RESP_DECERR;
                end else if (wcls == RESP_SLVERR || wlast_bad) begin
                    s_axi_io_bresp = RESP_SLVERR;
                end else begin
                    s_axi_io_bresp = RESP_OKAY;
                end
                if (s_axi_io_bready) begin
                    wstate_nxt = W_IDLE;
                end
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    // Write burst bookkeeping: latch on AW, step index/count per beat, flag wlast misuse.
    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            widx      <= s_axi_io_awaddr[DEPTH_LOG2+1:2];
            wlen      <= s_axi_io_awlen;
            wburst    <= s_axi_io_awburst;
            wcls      <= classify(s_axi_io_awaddr, s_axi_io_awburst);
            wcnt      <= 8'd0;
            wlast_bad <= 1'b0;
        end else if (w_hs) begin
            if (s_axi_io_wlast != w_final) begin
                wlast_bad <= 1'b1;
            end
            wcnt <= wcnt + 8'd1;
            if (wburst == BURST_INCR) begin
                widx <= widx + 1'b1;
            end
        end
    end

    // Byte-enabled memory write; error bursts are acknowledged but never stored.
    always_ff @(posedge aclk) begin
        if (w_hs && wcls == RESP_OKAY) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_io_wstrb[b]) begin
                    mem[widx][8*b +: 8] <= s_axi_io_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rstate <= R_IDLE;
        end else begin
            rstate <= rstate_nxt;
        end
    end

    // Read FSM next state and AR/R outputs; rdata is an asynchronous read of the current word.
    always_comb begin
        rstate_nxt       = rstate;
        s_axi_io_arready = 1'b0;
        s_axi_io_rvalid  = 1'b0;
        s_axi_io_rlast   = 1'b0;
        s_axi_io_rresp   = RESP_OKAY;
        s_axi_io_rdata   = 32'd0;
        case (rstate)
            R_IDLE: begin
                s_axi_io_arready = !areset;
                if (s_axi_io_arvalid && !areset) begin
                    rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                s_axi_io_rvalid = 1'b1;
                s_axi_io_rlast  = r_final;
                s_axi_io_rresp  = rcls;
                if (rcls == RESP_OKAY) begin
                    s_axi_io_rdata = mem[ridx];
                end
                if (s_axi_io_rready && r_final) begin
                    rstate_nxt = R_IDLE;
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    // Read burst bookkeeping: latch on AR, step index/count on each accepted beat.
    always_ff @(posedge aclk) begin
        if (ar_hs) begin
            ridx   <= s_axi_io_araddr[DEPTH_LOG2+1:2];
            rlen   <= s_axi_io_arlen;
            rburst <= s_axi_io_arburst;
            rcls   <= classify(s_axi_io_araddr, s_axi_io_arburst);
            rcnt   <= 8'd0;
        end else if (r_hs && !r_final) begin
            rcnt <= rcnt + 8'd1;
            if (rburst == BURST_INCR) begin
                ridx <= ridx + 1'b1;
            end
        end
    end

endmodule
